nubus_memory_ctrl: RTL
======================

Name: nubus_memory_ctrl

Overview:
- Parametrised NuBus slave memory that replaces the fixed-wait, fully combinational memory model.
- Captures each access, applies a configurable wait-state count, commits byte-strobed writes and returns registered read data with a single-cycle ready pulse.
- Sits behind the NuBus slave decoder; a card uses it as on-card RAM, and a bench uses it as a target model.

Parameters:
- ADDR_W, 10, word-address width; depth = 2**ADDR_W 32-bit words, indexed by mem_addr[ADDR_W+1:2].
- WAIT_CLOCKS, 0, extra wait cycles inserted before ready (0..255).
- ACCEPT_EXP, 0, when 1 an access is also accepted on mem_myexp (expansion space), not only on mem_myslot.

Ports:
- mem_clk      input   1   clock
- mem_reset    input   1   reset
- mem_valid    input   1   access request; held high until the access is acknowledged
- mem_wstrb    input   4   byte write strobes; 0 means a read
- mem_addr     input   32  byte address; bits [1:0] are ignored
- mem_wdata    input   32  write data
- mem_myslot   input   1   the address decodes to this card's slot space
- mem_myexp    input   1   the address decodes to this card's expansion space
- mem_rdata_o  output  32  read data; valid only while mem_ready_o is high on a read
- mem_ready_o  output  1   one-cycle acknowledge
- mem_write_o  output  1   the captured access is a write
- mem_busy_o   output  1   an access is in progress (FSM not in IDLE)

Interface: reset mem_reset, asynchronous, active-high; clock mem_clk.

Behaviour:
- Select: sel = mem_valid & (mem_myslot | (ACCEPT_EXP & mem_myexp)).
- Reset: FSM=IDLE; mem_rdata_o=0, mem_ready_o=0, mem_write_o=0, mem_busy_o=0; counter=0. Memory array is NOT cleared; contents are undefined until written.
- FSM states IDLE, WAIT, ACK, HOLD:
  - IDLE: on sel at edge E0, capture addr/wstrb/wdata, set mem_write_o=|wstrb, load cnt=WAIT_CLOCKS, go to WAIT.
  - WAIT: if !mem_valid, abort to IDLE (no write, no ready, mem_write_o cleared). Else if cnt==0, go to ACK. Else decrement cnt.
  - ACK (entry edge): a write updates only the strobed bytes; a read loads mem_rdata_o from the array. mem_ready_o=1 for exactly this one cycle. Next state is HOLD.
  - HOLD: mem_ready_o=0, mem_rdata_o=0; wait for !mem_valid, then IDLE (mem_write_o, mem_busy_o cleared). This prevents a held mem_valid from double-committing.
- Latency: mem_ready_o rises WAIT_CLOCKS+2 edges after E0; it first appears after edge E0+WAIT_CLOCKS+2.
- mem_rdata_o is 0 outside the ACK cycle of a read. During a write ACK it is 0.
- Inputs are ignored after capture. Changes to addr/wdata/wstrb mid-access have no effect.
- mem_myslot/mem_myexp are sampled only in IDLE.
- Back-to-back accesses require mem_valid low for at least one cycle; the minimum access period is WAIT_CLOCKS+4 cycles.
- Reset asserted mid-access: immediate return to IDLE with outputs at reset values. A write whose ACK edge has not occurred is not committed.
- Address wrap: bits above ADDR_W+1 are ignored, so addresses alias modulo 4*2**ADDR_W bytes.

Optional Feature:
- Macro: NUBUS_MEMORY_PARITY_EN.
- Defined:
  - A 4-bit even-parity array (one bit per byte) is added.
  - Written bytes store their parity; unwritten bytes keep their old parity.
  - On a read ACK, adds output mem_perr_o (1 bit), =1 for the ACK cycle if any stored parity mismatches; reset value 0.
  - Test hook: mem_addr[31] set on a write stores inverted parity.
- Undefined: no parity array, no mem_perr_o port, and mem_addr[31] is ignored as above.

Test Plan:
- Write with WAIT_CLOCKS=0: wstrb=4'hF, addr=0x10, data=0xDEADBEEF. Then read addr=0x10 -> ready 2 edges after valid; rdata=0xDEADBEEF during the one ready cycle and 0 otherwise.
- Partial strobes: write 0x11223344 with 4'hF, then 0xAABBCCDD with wstrb=4'b0101 to addr 0x20 -> read returns 0x11BB33DD.
- WAIT_CLOCKS=3: read with valid held -> ready exactly 5 edges after the capture edge, high 1 cycle; mem_busy_o stays high until valid drops.
- Abort: valid dropped in WAIT during a write of 0xCAFEF00D to addr 0x30 (prior contents 0x0) -> no ready; a later read returns 0x00000000.
- Select and alias:
  - valid with myslot=0, myexp=1, ACCEPT_EXP=0 -> no response, busy stays 0.
  - ACCEPT_EXP=1 -> access accepted.
  - ADDR_W=4: write to 0x40 is read back from 0x00.
- Reset mid-WAIT: assert mem_reset during WAIT of a write -> outputs 0 immediately, write not committed; the next access completes normally.

Source files
------------

// File: rtl/nubus_memory_ctrl.sv
// NuBus slave memory: captures an access, inserts WAIT_CLOCKS wait cycles,
// commits byte-strobed writes and returns registered read data with a
// single-cycle ready pulse. Optional byte parity is enabled by defining
// NUBUS_MEMORY_PARITY_EN, which adds the mem_perr_o output.
module nubus_memory_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CLOCKS = 0,
    parameter int ACCEPT_EXP  = 0
) (
    input  logic        mem_clk,
    input  logic        mem_reset,
    input  logic        mem_valid,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_myslot,
    input  logic        mem_myexp,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        mem_write_o,
    output logic        mem_busy_o
`ifdef NUBUS_MEMORY_PARITY_EN
    ,
    output logic        mem_perr_o
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [7:0]          r_cnt;
    logic [ADDR_W-1:0]   r_wordAddr;
    logic [3:0]          r_wstrb;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem [0:DEPTH-1];
    logic                w_sel;
    logic                w_expEn;
    logic                w_unused;

    assign w_expEn    = (ACCEPT_EXP != 0);
    assign w_sel      = mem_valid & (mem_myslot | (w_expEn & mem_myexp));
    assign mem_busy_o = (r_state != ST_IDLE);
    assign w_unused   = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    // State register; reset drops any access in flight straight back to idle
    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) r_state <= ST_IDLE;
        else           r_state <= w_nextState;
    end

    // Next-state: the HOLD state waits for valid to drop so a held request commits only once
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            ST_IDLE: if (w_sel) w_nextState = ST_WAIT;
            ST_WAIT: begin
                if (!mem_valid)      w_nextState = ST_IDLE;
                else if (r_cnt == 0) w_nextState = ST_ACK;
            end
            ST_ACK:  w_nextState = ST_HOLD;
            ST_HOLD: if (!mem_valid) w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Access capture, wait counter and registered response outputs
    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            r_cnt       <= '0;
            r_wordAddr  <= '0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            mem_write_o <= 1'b0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
        end else begin
            mem_ready_o <= (r_state == ST_ACK);
            mem_rdata_o <= (r_state == ST_ACK && !mem_write_o) ? r_mem[r_wordAddr] : '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_sel) begin
                        r_wordAddr  <= mem_addr[ADDR_W+1:2];
                        r_wstrb     <= mem_wstrb;
                        r_wdata     <= mem_wdata;
                        mem_write_o <= |mem_wstrb;
                        r_cnt       <= 8'(WAIT_CLOCKS);
                    end
                end
                ST_WAIT: begin
                    if (!mem_valid)     mem_write_o <= 1'b0;
                    else if (r_cnt != 0) r_cnt      <= r_cnt - 8'd1;
                end
                ST_HOLD: if (!mem_valid) mem_write_o <= 1'b0;
                default: ;
            endcase
        end
    end

    // Storage array is deliberately not reset; only strobed bytes change on a write ACK
    always_ff @(posedge mem_clk) begin
        if (r_state == ST_ACK && mem_write_o) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) r_mem[r_wordAddr][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

`ifdef NUBUS_MEMORY_PARITY_EN
    logic [3:0] r_par [0:DEPTH-1];
    logic       r_addrMsb;
    logic [3:0] w_rdParity;

    // Even parity of each byte of the word currently addressed
    always_comb begin
        w_rdParity = '0;
        for (int b = 0; b < 4; b++) w_rdParity[b] = ^r_mem[r_wordAddr][8*b +: 8];
    end

    // Parity error flag and captured address bit 31, which inverts stored parity for fault injection
    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            r_addrMsb  <= 1'b0;
            mem_perr_o <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_sel) r_addrMsb <= mem_addr[31];
            mem_perr_o <= (r_state == ST_ACK && !mem_write_o) ?
                          |(r_par[r_wordAddr] ^ w_rdParity) : 1'b0;
        end
    end

    // Parity array follows the data array byte for byte
    always_ff @(posedge mem_clk) begin
        if (r_state == ST_ACK && mem_write_o) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) r_par[r_wordAddr][b] <= (^r_wdata[8*b +: 8]) ^ r_addrMsb;
            end
        end
    end
`endif

endmodule
